// File: rtl/rx_iq_correct_if.sv
// Settings bus plus sample in/out streams of the IQ-imbalance corrector.
// The host/bench side uses master; the corrector uses slave.
interface rx_iq_correct_if #(
   parameter int WIDTH = 14
);
   logic                    set_stb;
   logic [7:0]              set_addr;
   logic [31:0]             set_data;
   logic                    in_stb;
   logic signed [WIDTH-1:0] in_i;
   logic signed [WIDTH-1:0] in_q;
   logic                    out_stb;
   logic signed [WIDTH-1:0] out_i;
   logic signed [WIDTH-1:0] out_q;
   logic [15:0]             ovf_count;

   modport master (
      output set_stb, set_addr, set_data, in_stb, in_i, in_q,
      input  out_stb, out_i, out_q, ovf_count
   );

   modport slave (
      input  set_stb, set_addr, set_data, in_stb, in_i, in_q,
      output out_stb, out_i, out_q, ovf_count
   );
endinterface

// File: rtl/rx_iq_correct.sv
// IQ-imbalance correction: I gets a gain term, Q gets an I cross-term.
// One lane per output channel; both lanes multiply the I sample.
module rx_iq_lane #(
   parameter int WIDTH = 14
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic signed [WIDTH-1:0] mul_in,
   input  logic signed [WIDTH-1:0] base_in,
   input  logic signed [17:0]      coef,
   input  logic                    bypass,
   output logic signed [WIDTH-1:0] res,
   output logic                    sat
);
   localparam int PW = WIDTH + 18;
   localparam int SW = WIDTH + 2;
   localparam logic signed [SW-1:0] MAXV = {3'b000, {(WIDTH-1){1'b1}}};
   localparam logic signed [SW-1:0] MINV = {3'b111, {(WIDTH-1){1'b0}}};

   logic signed [WIDTH-1:0] base2;
   logic signed [PW-1:0]    prod2;
   logic signed [PW-1:0]    rnd;
   logic signed [SW-1:0]    sum;
   logic signed [WIDTH-1:0] clip;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base2 <= '0;
         prod2 <= '0;
         res   <= '0;
      end else begin
         base2 <= base_in;
         prod2 <= PW'(mul_in) * PW'(coef);
         res   <= clip;
      end
   end

   // Round half up at the 2^-17 point; the result always fits in WIDTH+1 bits.
   assign rnd = (prod2 + PW'(65536)) >>> 17;
   assign sum = SW'(base2) + SW'(rnd);

   always_comb begin
      clip = sum[WIDTH-1:0];
      sat  = 1'b0;
      if (bypass) begin
         clip = base2;
      end else if (sum > MAXV) begin
         clip = MAXV[WIDTH-1:0];
         sat  = 1'b1;
      end else if (sum < MINV) begin
         clip = MINV[WIDTH-1:0];
         sat  = 1'b1;
      end
   end
endmodule

module rx_iq_correct #(
   parameter int WIDTH = 14,
   parameter int BASE  = 0
) (
   input logic             clk,
   input logic             rst_n,
   rx_iq_correct_if.slave  bus
);
   localparam int STAGES = 3;
   localparam int NUM_LANES = 2;

   logic [STAGES:1]                   vld_pipe;
   logic [NUM_LANES-1:0][WIDTH-1:0]   s1_smp;
   logic [NUM_LANES-1:0][17:0]        coef;
   logic [NUM_LANES-1:0][WIDTH-1:0]   res;
   logic [NUM_LANES-1:0]              lane_sat;
   logic [17:0]                       shadow_mag;
   logic [17:0]                       active_mag;
   logic [17:0]                       active_phase;
   logic                              ctrl_bypass;
   logic [15:0]                       ovf;
   logic                              hit_mag, hit_ph, hit_ctrl, ovf_clr;

   assign hit_mag  = bus.set_stb && (bus.set_addr == 8'(BASE));
   assign hit_ph   = bus.set_stb && (bus.set_addr == 8'(BASE + 1));
   assign hit_ctrl = bus.set_stb && (bus.set_addr == 8'(BASE + 2));
   assign ovf_clr  = hit_ctrl && bus.set_data[8];

   // Commit moves shadow mag and new phase together so a sample never
   // sees a half-updated pair.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_mag   <= '0;
         active_mag   <= '0;
         active_phase <= '0;
         ctrl_bypass  <= 1'b0;
      end else begin
         if (hit_mag)  shadow_mag <= bus.set_data[17:0];
         if (hit_ph) begin
            active_mag   <= shadow_mag;
            active_phase <= bus.set_data[17:0];
         end
         if (hit_ctrl) ctrl_bypass <= bus.set_data[0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         s1_smp   <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_stb};
         s1_smp   <= {bus.in_q, bus.in_i};
      end
   end

   assign coef = {active_phase, active_mag};

   // Lane 0 corrects I with the gain term, lane 1 adds the I cross-term to Q.
   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      rx_iq_lane #(.WIDTH(WIDTH)) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .mul_in  ($signed(s1_smp[0])),
         .base_in ($signed(s1_smp[g])),
         .coef    ($signed(coef[g])),
         .bypass  (ctrl_bypass),
         .res     (res[g]),
         .sat     (lane_sat[g])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= '0;
      end else if (ovf_clr) begin
         ovf <= '0;
      end else if (vld_pipe[STAGES-1] && (|lane_sat) && (ovf != 16'hFFFF)) begin
         ovf <= ovf + 16'd1;
      end
   end

   assign bus.out_stb   = vld_pipe[STAGES];
   assign bus.out_i     = $signed(res[0]);
   assign bus.out_q     = $signed(res[1]);
   assign bus.ovf_count = ovf;
endmodule

// File: tb/tb_rx_iq_correct.sv
// Directed-vector bench for rx_iq_correct with hand-computed expectations.
module tb_rx_iq_correct;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_chk = 0;
   int n_bad = 0;

   rx_iq_correct_if #(.WIDTH(14)) bus ();

   rx_iq_correct #(.WIDTH(14), .BASE(0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] addr, input logic [31:0] data);
      bus.set_stb  = 1'b1;
      bus.set_addr = addr;
      bus.set_data = data;
      step();
      bus.set_stb  = 1'b0;
   endtask

   task automatic sample1(input string tag, input int i, input int q, input int ei, input int eq);
      bus.in_stb = 1'b1;
      bus.in_i   = 14'(i);
      bus.in_q   = 14'(q);
      step();
      bus.in_stb = 1'b0;
      step();
      chk({tag, "_stb_early"}, int'(bus.out_stb), 0);
      step();
      chk({tag, "_stb"}, int'(bus.out_stb), 1);
      chk({tag, "_i"}, int'(bus.out_i), ei);
      chk({tag, "_q"}, int'(bus.out_q), eq);
   endtask

   initial begin
      bus.set_stb  = 1'b0;
      bus.set_addr = '0;
      bus.set_data = '0;
      bus.in_stb   = 1'b0;
      bus.in_i     = '0;
      bus.in_q     = '0;
      #12;
      chk("rst_stb", int'(bus.out_stb), 0);
      chk("rst_i", int'(bus.out_i), 0);
      chk("rst_q", int'(bus.out_q), 0);
      chk("rst_ovf", int'(bus.ovf_count), 0);
      rst_n = 1'b1;
      step();

      sample1("ident", 1000, -500, 1000, -500);

      // shadow write alone must not change the active gain
      wr(8'd0, 32'd65536);
      sample1("nocommit", 1000, 0, 1000, 0);
      wr(8'd1, 32'd0);
      sample1("gain", 1000, 0, 1500, 0);

      wr(8'd0, 32'd0);
      wr(8'd1, 32'h0003_8000);
      sample1("phase", 4000, 100, 4000, -900);

      wr(8'd0, 32'd131071);
      wr(8'd1, 32'd0);
      for (int k = 0; k < 5; k++) sample1("satpos", 8000, 0, 8191, 0);
      chk("ovf5", int'(bus.ovf_count), 5);
      wr(8'd9, 32'h0000_0100);
      chk("ovf_badaddr", int'(bus.ovf_count), 5);
      wr(8'd2, 32'h0000_0100);
      chk("ovf_clr", int'(bus.ovf_count), 0);
      sample1("satneg", -8192, 0, -8192, 0);
      chk("ovf_neg", int'(bus.ovf_count), 1);
      wr(8'd2, 32'h0000_0101);
      chk("ovf_clr2", int'(bus.ovf_count), 0);
      sample1("bypass", 8000, 0, 8000, 0);
      chk("ovf_byp", int'(bus.ovf_count), 0);
      wr(8'd2, 32'd0);

      // commit mid-stream: sample taken on the commit edge already sees new mag
      wr(8'd0, 32'd0);
      wr(8'd1, 32'd0);
      wr(8'd0, 32'd65536);
      bus.in_stb = 1'b1;
      bus.in_i   = 14'(2000);
      bus.in_q   = 14'(0);
      for (int e = 1; e <= 10; e++) begin
         if (e == 5) begin
            bus.set_stb  = 1'b1;
            bus.set_addr = 8'd1;
            bus.set_data = 32'd0;
         end
         step();
         bus.set_stb = 1'b0;
         if (e >= 3) begin
            chk($sformatf("atomic_stb%0d", e), int'(bus.out_stb), 1);
            chk($sformatf("atomic_i%0d", e), int'(bus.out_i), (e >= 7) ? 3000 : 2000);
         end
      end
      bus.in_stb = 1'b0;
      step();
      step();
      step();

      // async reset with a full pipe, dropped between edges
      bus.in_stb = 1'b1;
      bus.in_i   = 14'(1000);
      bus.in_q   = 14'(700);
      step();
      step();
      step();
      chk("pre_rst_stb", int'(bus.out_stb), 1);
      chk("pre_rst_i", int'(bus.out_i), 1500);
      bus.in_stb = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_stb", int'(bus.out_stb), 0);
      chk("arst_i", int'(bus.out_i), 0);
      chk("arst_q", int'(bus.out_q), 0);
      #3;
      rst_n = 1'b1;
      for (int e = 0; e < 4; e++) begin
         step();
         chk($sformatf("post_rst_stb%0d", e), int'(bus.out_stb), 0);
      end
      sample1("post_rst_ident", 1000, -500, 1000, -500);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
